hdmi_fb_arbiter: RTL and testbench
==================================

# hdmi_fb_arbiter

Shares the single read port of the HDMI window framebuffer between two requesters in the `clk` domain, e.g. the LED panel scanner and the host readback path. Each requester asks for a raster-order burst of pixels starting at (x, y). The arbiter grants round-robin, walks the framebuffer addresses one pixel per cycle, and returns tagged RGB data. Pixels outside the stored window read back as zero.

## Interface
Parameters:
- `WIDTH`, default 128: window width in pixels; must match the framebuffer.
- `HEIGHT`, default 100: window height in pixels.
- `LEN_BITS`, default 8: width of the burst length field.

Ports:
- `clk`  in  1  single clock; framebuffer read clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req0`, `req1`  in  1  burst request; hold high until the matching `ack`.
- `x0`, `y0`, `x1`, `y1`  in  12  start coordinate in framebuffer space.
- `len0`, `len1`  in  LEN_BITS  pixel count minus 1 (0 = 1 pixel).
- `ack0`, `ack1`  out  1  one-cycle pulse: burst accepted, inputs sampled.
- `pix_valid0`, `pix_valid1`  out  1  returned pixel belongs to requester 0 / 1.
- `pix_last`  out  1  final pixel of the current burst.
- `r`, `g`, `b`  out  8  returned pixel data, shared by both requesters.
- `fb_xaddr`, `fb_yaddr`  out  12  framebuffer read address.
- `fb_r`, `fb_g`, `fb_b`  in  8  framebuffer read data, 1-cycle synchronous latency.

## Operation
- States:
  - IDLE: no burst in progress; the arbiter evaluates requests here.
  - RUN: the arbiter is walking a burst.
- IDLE, no request: stay in IDLE.
- IDLE, one request: grant that requester.
  - Latch x, y, len and the owner.
  - Pulse `ack` on the next cycle.
  - Go to RUN.
- IDLE, both requests: the requester named by priority pointer `prio` wins. After reset `prio` = 0.
- On every grant, `prio` becomes the other requester (round-robin).
- RUN issues one address per cycle, starting with (x, y).
- Address stepping:
  - x increments each cycle.
  - When x = WIDTH-1, x wraps to 0 and y increments.
- A remaining-count register decrements each cycle. When it reaches 0 after issuing, return to IDLE.
- Bursts are always separated by at least one IDLE cycle. There is no preemption; a granted burst runs to completion.
- Range check:
  - An address with x ≥ WIDTH or y ≥ HEIGHT is out of range.
  - For an out-of-range address, hold `fb_xaddr`/`fb_yaddr` at 0 and force the returned r/g/b to 0.
  - The out-of-range pixel still occupies its slot and still asserts `pix_valid`.
- A `req` that is low when sampled in IDLE is not granted. Dropping `req` after `ack` has no effect on the burst.
- Request inputs are ignored while in RUN.
- Coordinate arithmetic is 12-bit. y saturates at 4095 and does not wrap; such pixels are out of range and return 0.
- The return pipeline tags each slot with owner, out-of-range flag and last flag. These tags travel alongside the RAM latency.

## Timing
- Cycle A: IDLE, and the arbiter sees `req`.
- A+1: `ack` pulses, `fb_*addr` = first address, state = RUN.
- A+2: the framebuffer presents data.
- A+3: `pix_valid`, r/g/b and `pix_last` are registered outputs. First-pixel latency from request is 3 cycles.
- A burst of N pixels occupies address cycles A+1 .. A+N. `pix_last` occurs at A+N+2.
- The earliest next grant is decided at A+N+1, with its `ack` at A+N+2.
- The return pipeline keeps draining after the state returns to IDLE.
- Reset values: all outputs 0, state IDLE, `prio` 0, pipeline valid bits 0.
- Reset asserted mid-burst discards in-flight pixels immediately. No `pix_valid` appears after reset.

## Structure
- Shared include `hdmi_fb_defs.vh` holds:
  - state encodings `FBA_IDLE` and `FBA_RUN`;
  - default window size `FB_WIDTH` = 128 and `FB_HEIGHT` = 100, also used by `hdmi_framebuffer`;
  - `FB_RD_LATENCY` = 1.
- One sub-module, `fb_raster_walker`:
  - loads (x, y, len);
  - steps x/y with the wrap and saturation rules above;
  - outputs the address, an out-of-range flag and a last flag.
- The arbiter FSM, `prio` and the return pipeline stay in `hdmi_fb_arbiter`.

## Test plan
- Single request: `req0` with x=5, y=2, len=3. Expect `ack0` at A+1 and addresses (5,2)..(8,2). Expect 4 `pix_valid0` pulses carrying the memory contents, with `pix_last` on the 4th.
- Row wrap: `req1` with x=126, y=0, len=3. Expect addresses (126,0), (127,0), (0,1), (1,1).
- Window edge: `req0` with x=127, y=99, len=1. Expect pixel 1 from memory and pixel 2 out of range (returns 0, fb address 0), 2 valids total.
- Contention: `req0` and `req1` both high from reset, each with len=0. Expect grant order 0, 1, 0, 1. Bursts separated by one IDLE cycle, and `ack` never asserted for both requesters in the same cycle.
- Withdrawal: `req1` is pulsed high for one cycle while the arbiter is in RUN. Expect `ack1` never and `pix_valid1` never.
- Reset mid-burst: `reset` asserted at A+3 of a len=10 burst. Expect all outputs 0 immediately and no further `pix_valid` after release.

Source files
------------

// File: rtl/hdmi_fb_arbiter_pkg.sv
// Shared types and constants for the framebuffer read-port arbiter.
// The window size defaults are also used by the framebuffer itself.
package hdmi_fb_arbiter_pkg;
  localparam int FB_WIDTH      = 128;
  localparam int FB_HEIGHT     = 100;
  localparam int FB_RD_LATENCY = 1;
  localparam int COORD_W       = 12;

  typedef enum logic {
    FBA_IDLE = 1'b0,
    FBA_RUN  = 1'b1
  } fba_state_e;

  // Per-slot tag carried alongside the framebuffer read latency
  typedef struct packed {
    logic vld;
    logic owner;
    logic oor;
    logic last;
  } pix_tag_t;
endpackage

// File: rtl/hdmi_fb_arbiter_if.sv
// Requester, pixel-return and framebuffer read-port signals of the arbiter.
interface hdmi_fb_arbiter_if
  import hdmi_fb_arbiter_pkg::*;
#(
  parameter int LEN_BITS = 8
) ();
  logic                req0, req1;
  logic [COORD_W-1:0]  x0, y0, x1, y1;
  logic [LEN_BITS-1:0] len0, len1;
  logic                ack0, ack1;
  logic                pix_valid0, pix_valid1, pix_last;
  logic [7:0]          r, g, b;
  logic [COORD_W-1:0]  fb_xaddr, fb_yaddr;
  logic [7:0]          fb_r, fb_g, fb_b;

  modport slave (
    input  req0, req1, x0, y0, x1, y1, len0, len1, fb_r, fb_g, fb_b,
    output ack0, ack1, pix_valid0, pix_valid1, pix_last, r, g, b, fb_xaddr, fb_yaddr
  );

  modport master (
    output req0, req1, x0, y0, x1, y1, len0, len1, fb_r, fb_g, fb_b,
    input  ack0, ack1, pix_valid0, pix_valid1, pix_last, r, g, b, fb_xaddr, fb_yaddr
  );
endinterface

// File: rtl/hdmi_fb_arbiter_walker.sv
// Raster-order address walker: steps x with row wrap, y saturating at the
// top of the 12-bit range, and flags out-of-window and final addresses.
module fb_raster_walker
  import hdmi_fb_arbiter_pkg::*;
#(
  parameter int WIDTH    = FB_WIDTH,
  parameter int HEIGHT   = FB_HEIGHT,
  parameter int LEN_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                step,
  input  logic [COORD_W-1:0]  x_in,
  input  logic [COORD_W-1:0]  y_in,
  input  logic [LEN_BITS-1:0] len_in,
  output logic [COORD_W-1:0]  x,
  output logic [COORD_W-1:0]  y,
  output logic                oor,
  output logic                last
);
  logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
  logic [LEN_BITS-1:0] rem_q, rem_d;

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    rem_d = rem_q;
    if (load) begin
      x_d   = x_in;
      y_d   = y_in;
      rem_d = len_in;
    end else if (step) begin
      rem_d = rem_q - LEN_BITS'(1);
      if (x_q == 12'(WIDTH - 1)) begin
        x_d = '0;
        y_d = (y_q == '1) ? y_q : y_q + 12'd1;
      end else begin
        x_d = x_q + 12'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q   <= '0;
      y_q   <= '0;
      rem_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      rem_q <= rem_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign oor  = ({20'd0, x_q} >= 32'(WIDTH)) || ({20'd0, y_q} >= 32'(HEIGHT));
  assign last = (rem_q == '0);
endmodule

// File: rtl/hdmi_fb_arbiter.sv
// Round-robin arbiter sharing the framebuffer read port between two burst
// requesters; returns tagged pixels three cycles after the request.
module hdmi_fb_arbiter
  import hdmi_fb_arbiter_pkg::*;
#(
  parameter int WIDTH    = FB_WIDTH,
  parameter int HEIGHT   = FB_HEIGHT,
  parameter int LEN_BITS = 8
) (
  input logic               clk,
  input logic               reset,
  hdmi_fb_arbiter_if.slave  bus
);
  fba_state_e         state_q;
  logic               prio_q, owner_q, ack0_q, ack1_q;
  logic               run, grant, win;
  logic [COORD_W-1:0] w_x, w_y;
  logic               w_oor, w_last;

  assign run   = (state_q == FBA_RUN);
  assign grant = !run && (bus.req0 || bus.req1);
  assign win   = (bus.req0 && bus.req1) ? prio_q : bus.req1;

  fb_raster_walker #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .LEN_BITS(LEN_BITS)) u_walker (
    .clk    (clk),
    .reset  (reset),
    .load   (grant),
    .step   (run),
    .x_in   (win ? bus.x1 : bus.x0),
    .y_in   (win ? bus.y1 : bus.y0),
    .len_in (win ? bus.len1 : bus.len0),
    .x      (w_x),
    .y      (w_y),
    .oor    (w_oor),
    .last   (w_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FBA_IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        FBA_IDLE: if (grant) begin
          state_q <= FBA_RUN;
          owner_q <= win;
          prio_q  <= ~win;
          ack0_q  <= ~win;
          ack1_q  <= win;
        end
        FBA_RUN: if (w_last) state_q <= FBA_IDLE;
        default: state_q <= FBA_IDLE;
      endcase
    end
  end

  // Tags for each issued address, delayed to line up with the read data
  pix_tag_t tag_pipe_d [FB_RD_LATENCY];
  pix_tag_t tag_pipe_q [FB_RD_LATENCY];
  pix_tag_t tail;
  logic       pv0_d, pv0_q, pv1_d, pv1_q, last_d, last_q;
  logic [23:0] rgb_d, rgb_q;

  always_comb begin
    tag_pipe_d[0] = '{vld: run, owner: owner_q, oor: w_oor, last: w_last};
    for (int i = 1; i < FB_RD_LATENCY; i++) tag_pipe_d[i] = tag_pipe_q[i-1];
  end

  assign tail = tag_pipe_q[FB_RD_LATENCY-1];

  always_comb begin
    pv0_d  = tail.vld && !tail.owner;
    pv1_d  = tail.vld && tail.owner;
    last_d = tail.vld && tail.last;
    rgb_d  = (tail.vld && !tail.oor) ? {bus.fb_r, bus.fb_g, bus.fb_b} : 24'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FB_RD_LATENCY; i++) tag_pipe_q[i] <= '0;
      pv0_q  <= 1'b0;
      pv1_q  <= 1'b0;
      last_q <= 1'b0;
      rgb_q  <= '0;
    end else begin
      for (int i = 0; i < FB_RD_LATENCY; i++) tag_pipe_q[i] <= tag_pipe_d[i];
      pv0_q  <= pv0_d;
      pv1_q  <= pv1_d;
      last_q <= last_d;
      rgb_q  <= rgb_d;
    end
  end

  assign bus.ack0       = ack0_q;
  assign bus.ack1       = ack1_q;
  assign bus.pix_valid0 = pv0_q;
  assign bus.pix_valid1 = pv1_q;
  assign bus.pix_last   = last_q;
  assign {bus.r, bus.g, bus.b} = rgb_q;
  // Out-of-window and idle cycles park the read port at (0,0)
  assign bus.fb_xaddr   = (run && !w_oor) ? w_x : '0;
  assign bus.fb_yaddr   = (run && !w_oor) ? w_y : '0;
endmodule

// File: tb/tb_hdmi_fb_arbiter.sv
// Directed plus randomized bursts against a coordinate-list reference model.
module tb_hdmi_fb_arbiter;
  localparam int W = 128;
  localparam int H = 100;

  typedef struct {
    bit          owner;
    logic [23:0] rgb;
    bit          last;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t expq[$];
  exp_t e;

  hdmi_fb_arbiter_if #(.LEN_BITS(8)) bus ();

  hdmi_fb_arbiter #(.WIDTH(W), .HEIGHT(H), .LEN_BITS(8)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] mem(input logic [11:0] x, input logic [11:0] y);
    return {x[7:0] ^ 8'h5A, y[7:0] + 8'd3, x[7:0] + y[7:0] + 8'h11};
  endfunction

  // Framebuffer model: one cycle of read latency
  always @(posedge clk) {bus.fb_r, bus.fb_g, bus.fb_b} <= mem(bus.fb_xaddr, bus.fb_yaddr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pixel return monitor
  always @(negedge clk) begin
    if (bus.ack0 || bus.ack1) chk("ack_both", 64'(bus.ack0 & bus.ack1), 64'd0);
    while (expq.size() > 0 && expq[0].cyc < cyc) begin
      chk("pix_missing", 64'(cyc), 64'(expq[0].cyc));
      void'(expq.pop_front());
    end
    if (bus.pix_valid0 || bus.pix_valid1) begin
      if (expq.size() == 0) begin
        chk("pix_unexpected", {bus.pix_valid0, bus.pix_valid1}, 64'd0);
      end else begin
        e = expq.pop_front();
        chk("pix_owner", {bus.pix_valid0, bus.pix_valid1}, {!e.owner, e.owner});
        chk("pix_rgb", {bus.r, bus.g, bus.b}, e.rgb);
        chk("pix_last", bus.pix_last, e.last);
        chk("pix_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Reference: list the burst's raster coordinates and the pixels it yields
  task automatic model(input bit who, input int x, input int y, input int len, input int ca,
                       output int ax[$], output int ay[$]);
    int cx = x, cy = y;
    bit oor;
    ax = {};
    ay = {};
    for (int k = 0; k <= len; k++) begin
      oor = (cx >= W) || (cy >= H);
      ax.push_back(oor ? 0 : cx);
      ay.push_back(oor ? 0 : cy);
      expq.push_back('{who, oor ? 24'd0 : mem(12'(cx), 12'(cy)), k == len, ca + 3 + k});
      if (cx == W - 1) begin
        cx = 0;
        cy = (cy >= 4095) ? 4095 : cy + 1;
      end else begin
        cx = (cx + 1) % 4096;
      end
    end
  endtask

  task automatic burst(input bit who, input int x, input int y, input int len, input int pulse_at);
    int ax[$], ay[$];
    int ca;
    @(negedge clk);
    if (!who) begin
      bus.req0 = 1'b1; bus.x0 = 12'(x); bus.y0 = 12'(y); bus.len0 = 8'(len);
    end else begin
      bus.req1 = 1'b1; bus.x1 = 12'(x); bus.y1 = 12'(y); bus.len1 = 8'(len);
    end
    ca = cyc;
    model(who, x, y, len, ca, ax, ay);
    @(posedge clk); #1;
    chk("ack", {bus.ack0, bus.ack1}, {!who, who});
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.x0 = 12'($urandom); bus.y0 = 12'($urandom); bus.len0 = 8'($urandom);
    bus.x1 = 12'($urandom); bus.y1 = 12'($urandom); bus.len1 = 8'($urandom);
    for (int k = 0; k <= len; k++) begin
      chk("addr", {bus.fb_xaddr, bus.fb_yaddr}, {12'(ax[k]), 12'(ay[k])});
      if (k > 0) chk("ack_run", {bus.ack0, bus.ack1}, 64'd0);
      if (k == pulse_at) begin
        if (who) bus.req0 = 1'b1; else bus.req1 = 1'b1;
      end
      if (k == pulse_at + 1) begin
        bus.req0 = 1'b0; bus.req1 = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    chk("idle_addr", {bus.fb_xaddr, bus.fb_yaddr, bus.ack0, bus.ack1}, 64'd0);
  endtask

  initial begin
    int ca, own, len, pulse;
    int ax[$], ay[$];
    // Contention: both requesters high out of reset, len 0
    bus.req0 = 1'b1; bus.x0 = 12'd10; bus.y0 = 12'd3; bus.len0 = 8'd0;
    bus.req1 = 1'b1; bus.x1 = 12'd20; bus.y1 = 12'd4; bus.len1 = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus.ack0, bus.ack1, bus.pix_valid0, bus.pix_valid1, bus.pix_last,
                          bus.r, bus.g, bus.b, bus.fb_xaddr, bus.fb_yaddr}, 64'd0);
    rst = 1'b0;
    ca = cyc;
    for (int i = 0; i < 4; i++) begin
      own = i % 2;
      model(own[0], own ? 20 : 10, own ? 4 : 3, 0, ca, ax, ay);
      @(posedge clk); #1;
      chk("cont_ack", {bus.ack0, bus.ack1}, {own == 0, own == 1});
      chk("cont_addr", {bus.fb_xaddr, bus.fb_yaddr}, {12'(ax[0]), 12'(ay[0])});
      if (i == 3) begin
        bus.req0 = 1'b0; bus.req1 = 1'b0;
      end
      @(posedge clk); #1;
      chk("cont_gap", {bus.ack0, bus.ack1}, 64'd0);
      ca = ca + 2;
    end
    repeat (3) @(posedge clk);

    burst(1'b0, 5, 2, 3, -1);      // single request
    burst(1'b1, 126, 0, 3, -1);    // row wrap
    burst(1'b0, 127, 99, 1, -1);   // window edge
    burst(1'b0, 10, 10, 5, 2);     // withdrawal pulse on req1 during RUN
    repeat (4) @(posedge clk);
    chk("drain_before_reset", 64'(expq.size()), 64'd0);

    // Reset mid-burst at A+3 of a len=10 burst
    @(negedge clk);
    bus.req0 = 1'b1; bus.x0 = 12'd0; bus.y0 = 12'd0; bus.len0 = 8'd10;
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("reset_mid", {bus.ack0, bus.ack1, bus.pix_valid0, bus.pix_valid1, bus.pix_last,
                      bus.r, bus.g, bus.b, bus.fb_xaddr, bus.fb_yaddr}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("post_reset_pv", {bus.pix_valid0, bus.pix_valid1}, 64'd0);
    end

    // Randomized single-requester bursts, including window and saturation edges
    for (int i = 0; i < 25; i++) begin
      len   = $urandom_range(0, 40);
      pulse = (len > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
      case ($urandom_range(0, 3))
        0:       burst(1'($urandom), $urandom_range(0, 140), $urandom_range(0, 105), len, pulse);
        1:       burst(1'($urandom), $urandom_range(100, 140), $urandom_range(95, 104), len, pulse);
        2:       burst(1'($urandom), $urandom_range(110, 127), $urandom_range(4093, 4095), len, pulse);
        default: burst(1'($urandom), $urandom_range(0, 127), $urandom_range(0, 99), len, pulse);
      endcase
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end
    repeat (6) @(posedge clk);
    chk("final_drain", 64'(expq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
